// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter
//   Round-robin arbiter sharing one resource among N requesters. Rotating
//   priority lives in a one-hot ring pointer. The registered one-hot grant is
//   also presented as an OR-encoded binary index. An owner may be preempted
//   after MAX_HOLD consecutive cycles when someone else is waiting. Setting
//   MAX_HOLD to 0 disables preemption.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester level request, bit i = requester i
//   gnt        one-hot registered grant, all zeros when idle
//   gnt_valid  high when any gnt bit is set
//   gnt_idx    binary index of the set gnt bit, 0 when idle
module rr_ring_arbiter #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int HCNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  // With the timeout disabled the counter simply parks at 1.
  localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'((MAX_HOLD == 0) ? 1 : MAX_HOLD);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [N-1:0]        ptr_q, ptr_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;

  // OR-encode a one-hot (or zero) vector into its binary index.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // First set bit of r found by searching circularly from index start.
  function automatic logic [N-1:0] pick_first(input logic [N-1:0]     r,
                                              input logic [IDX_W-1:0] start);
    logic [N-1:0]     g;
    logic             found;
    logic [IDX_W-1:0] p;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      p = IDX_W'((int'(start) + k) % N);
      if (!found && r[p]) begin
        g[p]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  logic [N-1:0] ptr_rot;
  logic [N-1:0] winner;
  logic         own_req;
  logic         others_req;
  logic         at_max;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    hcnt_d     = hcnt_q;
    // Owner's position rotated by one; becomes the pointer on release.
    ptr_rot    = {gnt_q[N-2:0], gnt_q[N-1]};
    own_req    = |(req & gnt_q);
    others_req = |(req & ~gnt_q);
    at_max     = (MAX_HOLD != 0) && (hcnt_q == HOLD_LIM);
    winner     = pick_first(req & ~gnt_q, onehot_to_idx(ptr_rot));

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = pick_first(req, onehot_to_idx(ptr_q));
          hcnt_d  = HCNT_W'(1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!own_req || (at_max && others_req)) begin
          // Release: hand over on this same edge if anyone else is asking.
          ptr_d = ptr_rot;
          if (|winner) begin
            gnt_d  = winner;
            hcnt_d = HCNT_W'(1);
          end else begin
            gnt_d   = '0;
            hcnt_d  = '0;
            state_d = S_IDLE;
          end
        end else if (at_max) begin
          hcnt_d = HCNT_W'(1);
        end else if (hcnt_q < HOLD_LIM) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= N'(1);
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = onehot_to_idx(gnt_q);

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb_rr_ring_arbiter
//   Directed bench for rr_ring_arbiter (N=16, MAX_HOLD=4). Inputs change and
//   outputs are sampled on the falling clock edge.
module tb_rr_ring_arbiter;

  localparam int N        = 16;
  localparam int IDX_W    = 4;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  int n_checks;
  int n_fail;

  rr_ring_arbiter #(
    .N        (N),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then land on the following falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_grant(input string tag, input int idx);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
    check_eq({tag, "_vld"}, 32'(gnt_valid), 32'd1);
    check_eq({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_vld"}, 32'(gnt_valid), 32'd0);
    check_eq({tag, "_idx"}, 32'(gnt_idx), 32'd0);
  endtask

  int seq3 [5] = '{2, 7, 12, 2, 7};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 16'hFFFF;

    // 1. Reset holds everything at zero, first grant after release is 0.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_idle("rst_hold");
    end
    rst_n = 1'b1;
    cyc();
    check_grant("rst_first", 0);

    // 2. Single requester 5, then drop; pointer lands on 6.
    req = '0;
    cyc();
    check_idle("idle_after_0");
    req = 16'h0020;
    cyc();
    check_grant("r5_grant", 5);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_grant("r5_hold", 5);
    end
    req = '0;
    cyc();
    check_idle("r5_drop");
    check_eq("ptr_after5", 32'(dut.ptr_q), 32'h0040);
    req = 16'h00A0;
    cyc();
    check_grant("search_from6", 7);
    req = '0;
    cyc();
    check_idle("idle_after_7");

    // 4. Owner 15 drops while 0 and 14 wait: wrap to 0.
    req = 16'h8000;
    cyc();
    check_grant("r15_grant", 15);
    req = 16'hC001;
    cyc();
    check_grant("r15_keep", 15);
    req = 16'h4001;
    cyc();
    check_grant("wrap_to_0", 0);
    check_eq("ptr_wrap", 32'(dut.ptr_q), 32'h0001);

    // 3. Three contenders from reset, 4-cycle slices, no bubbles.
    rst_n = 1'b0;
    req   = 16'h1084;
    cyc();
    check_idle("rst2");
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        cyc();
        check_grant("rr_slice", seq3[g]);
      end
    end

    // 5. Lone requester 3 keeps the grant; hold counter wraps 1..4.
    req = 16'h0008;
    for (int c = 0; c < 20; c++) begin
      cyc();
      check_grant("lone3", 3);
      check_eq("lone3_hcnt", 32'(dut.hcnt_q), 32'((c % 4) + 1));
    end

    // 6. Asynchronous reset mid-grant of owner 9.
    req = 16'h0200;
    cyc();
    check_grant("r9_grant", 9);
    req = 16'h0208;
    cyc();
    check_grant("r9_keep", 9);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    #1;
    rst_n = 1'b1;
    cyc();
    check_grant("post_rst", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
